mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that sits as a responder on the processor data bus, alongside data RAM.
- The core drives addr/write_en/write_data and samples read_data in the same cycle, as it does for RAM.
- The block buffers written bytes in a small FIFO and serializes them onto a TX line in 8N1 format (one start bit, 8 data bits LSB first, one stop bit).
- Top-level address decode is not required: the block self-selects on BASE_ADDR.

---
 rtl/mmio_uart_tx_pkg.sv | 21 ++
 rtl/mmio_uart_tx_if.sv | 10 +
 rtl/mmio_uart_tx_sync_fifo.sv | 48 ++++
 rtl/mmio_uart_tx.sv | 179 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// rtl/mmio_uart_tx_pkg.sv - shared types and constants for the MMIO UART transmitter
package mmio_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - processor data-bus responder interface (same-cycle read, edge-sampled write)
interface mmio_uart_tx_if;
  logic [31:0] addr;
  logic        write_en;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output addr, output write_en, output write_data, input read_data);
  modport slave  (input addr, input write_en, input write_data, output read_data);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// rtl/mmio_uart_tx_sync_fifo.sv - synchronous FIFO with head-visible dout; caller guarantees legal push/pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // Storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO and baud divisor
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic           clk,
  input  logic           rst,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          w_sel;
  logic [1:0]    w_off;
  logic          w_wr_data;
  logic          w_wr_status;
  logic          w_wr_div;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_empty_next;
  logic [CW-1:0] w_count;
  logic [7:0]    w_fifo_dout;
  logic [31:0]   w_status;
  logic          w_cyc_last;
  logic          w_tx_next;
  logic          w_unused_bits;

  uart_state_e   r_state, w_state_next;
  logic [7:0]    r_shift, w_shift_next;
  logic [2:0]    r_bit, w_bit_next;
  logic [15:0]   r_cyc, w_cyc_next;
  logic [15:0]   r_div_shadow, w_div_shadow_next;
  logic [15:0]   r_div;
  logic          r_ovf;
  logic          r_tx;
  logic          r_irq;

  assign w_sel         = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_off         = bus.addr[3:2];
  assign w_wr_data     = w_sel && bus.write_en && (w_off == OFF_DATA);
  assign w_wr_status   = w_sel && bus.write_en && (w_off == OFF_STATUS);
  assign w_wr_div      = w_sel && bus.write_en && (w_off == OFF_DIV);
  assign w_unused_bits = ^{bus.addr[1:0], bus.write_data[31:16]};

  // A full FIFO still accepts a byte when the serializer frees the head this cycle.
  assign w_push = w_wr_data && (!w_full || w_pop);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.write_data[7:0]),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= DEFAULT_DIV;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_div) r_div <= (bus.write_data[15:0] == 16'd0) ? 16'd1 : bus.write_data[15:0];
      if (w_wr_status)                r_ovf <= 1'b0;
      else if (w_wr_data && !w_push)  r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit        <= '0;
      r_cyc        <= '0;
      r_div_shadow <= DEFAULT_DIV;
      r_tx         <= 1'b1;
      r_irq        <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_shift      <= w_shift_next;
      r_bit        <= w_bit_next;
      r_cyc        <= w_cyc_next;
      r_div_shadow <= w_div_shadow_next;
      r_tx         <= w_tx_next;
      r_irq        <= (w_state_next == IDLE) && w_empty_next;
    end
  end

  assign w_cyc_last = (r_cyc == r_div_shadow - 16'd1);

  always_comb begin
    w_state_next      = r_state;
    w_shift_next      = r_shift;
    w_bit_next        = r_bit;
    w_cyc_next        = r_cyc;
    w_div_shadow_next = r_div_shadow;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_next      = START;
          w_shift_next      = w_fifo_dout;
          w_div_shadow_next = r_div;
          w_cyc_next        = '0;
          w_bit_next        = '0;
        end
      end
      START: begin
        if (w_cyc_last) begin
          w_state_next = DATA;
          w_cyc_next   = '0;
        end else begin
          w_cyc_next = r_cyc + 16'd1;
        end
      end
      DATA: begin
        if (w_cyc_last) begin
          w_cyc_next   = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_next = STOP;
          else               w_bit_next   = r_bit + 3'd1;
        end else begin
          w_cyc_next = r_cyc + 16'd1;
        end
      end
      STOP: begin
        if (w_cyc_last) begin
          w_state_next = IDLE;
          w_cyc_next   = '0;
        end else begin
          w_cyc_next = r_cyc + 16'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // tx is registered from the next state so the line level lines up with the state it belongs to.
  always_comb begin
    w_pop = (r_state == IDLE) && !w_empty;
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
    w_empty_next = ((w_count == '0) && !w_push) ||
                   ((w_count == CW'(1)) && w_pop && !w_push);
  end

  always_comb begin
    w_status                          = '0;
    w_status[STAT_BUSY]               = (r_state != IDLE);
    w_status[STAT_FULL]               = w_full;
    w_status[STAT_EMPTY]              = w_empty;
    w_status[STAT_OVF]                = r_ovf;
    w_status[STAT_CNT_LSB +: CW]      = w_count;
  end

  always_comb begin
    bus.read_data = '0;
    if (w_sel) begin
      case (w_off)
        OFF_STATUS: bus.read_data = w_status;
        OFF_DIV:    bus.read_data = {16'd0, r_div};
        default:    bus.read_data = '0;
      endcase
    end
  end

  assign tx  = r_tx;
  assign irq = r_irq;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench: waveform-queue reference model plus directed literal checks
module tb_mmio_uart_tx;
  localparam logic [31:0] A_DATA   = 32'h0000_0400;
  localparam logic [31:0] A_STATUS = 32'h0000_0404;
  localparam logic [31:0] A_DIV    = 32'h0000_0408;
  localparam logic [31:0] A_RSVD   = 32'h0000_040C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, irq;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(
    .BASE_ADDR   (32'h0000_0400),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd434)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if),
    .tx  (tx),
    .irq (irq)
  );

  always #5 clk = ~clk;

  // Reference model: pending bytes, plus the exact line level for every remaining cycle of the frame.
  logic [7:0] m_fifo [$];
  bit         m_txq  [$];
  int         m_div = 434;
  bit         m_ovf = 1'b0;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] r;
    logic [27:0] win;
    r   = '0;
    win = 28'h000_0040;
    if (a[31:4] == win) begin
      if (a[3:2] == 2'd1)
        r = {24'd0, 4'(m_fifo.size()), m_ovf, (m_fifo.size() == 0), (m_fifo.size() == 8), (m_txq.size() > 0)};
      else if (a[3:2] == 2'd2)
        r = {16'd0, 16'(m_div)};
    end
    return r;
  endfunction

  always @(posedge clk) begin
    logic [7:0] b;
    bit         popnow;
    int         sz;
    if (rst) begin
      m_fifo.delete();
      m_txq.delete();
      m_div = 434;
      m_ovf = 1'b0;
    end else begin
      sz     = m_fifo.size();
      popnow = (m_txq.size() == 0) && (sz > 0);
      if (m_txq.size() > 0) begin
        void'(m_txq.pop_front());
      end else if (popnow) begin
        b = m_fifo.pop_front();
        for (int k = 0; k < 10; k++)
          for (int c = 0; c < m_div; c++)
            m_txq.push_back((k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1]);
      end
      if (bus_if.write_en && (bus_if.addr[31:4] == 28'h000_0040)) begin
        case (bus_if.addr[3:2])
          2'd0: if (sz < 8 || popnow) m_fifo.push_back(bus_if.write_data[7:0]);
                else m_ovf = 1'b1;
          2'd1: m_ovf = 1'b0;
          2'd2: m_div = (bus_if.write_data[15:0] == 16'd0) ? 1 : int'(bus_if.write_data[15:0]);
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_tx",   {31'd0, tx},  {31'd0, (m_txq.size() > 0) ? m_txq[0] : 1'b1});
      chk("model_irq",  {31'd0, irq}, {31'd0, (m_txq.size() == 0) && (m_fifo.size() == 0)});
      chk("model_read", bus_if.read_data, model_rd(bus_if.addr));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_if.addr = a; bus_if.write_en = 1'b1; bus_if.write_data = d;
    @(posedge clk); #1;
    bus_if.write_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_if.addr = a; bus_if.write_en = 1'b0;
    @(negedge clk);
    d = bus_if.read_data;
    @(posedge clk); #1;
  endtask

  // Samples tx and busy on the next n negedges, leaving the bench just after a posedge.
  task automatic capture(input int n, output bit txs[200], output bit bsy[200]);
    bus_if.addr = A_STATUS; bus_if.write_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      txs[i] = tx;
      bsy[i] = bus_if.read_data[0];
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    bit txs[200];
    bit bsy[200];
    bit fb[10];
    int n, runs, lastrun, cur, gap, ones;
    fb = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    bus_if.addr = '0; bus_if.write_en = 1'b0; bus_if.write_data = '0;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    chk_en = 1'b1;

    rd(A_STATUS, d); chk("reset_status", d, 32'h0000_0004);
    rd(A_DIV, d);    chk("reset_div", d, 32'd434);
    chk("reset_tx",  {31'd0, tx},  32'd1);
    chk("reset_irq", {31'd0, irq}, 32'd1);
    rd(32'h0000_0804, d); chk("outside_read", d, 32'd0);
    rd(A_RSVD, d);        chk("reserved_read", d, 32'd0);

    wr(A_DIV, 32'd4);
    wr(A_DATA, 32'h55);
    capture(44, txs, bsy);
    chk("pre_start_tx", {31'd0, txs[0]}, 32'd1);
    for (int j = 1; j <= 40; j++)
      chk($sformatf("frame55_tx[%0d]", j), {31'd0, txs[j]}, {31'd0, fb[(j-1)/4]});
    n = 0;
    for (int j = 0; j < 44; j++) n += bsy[j];
    chk("busy_cycles_div4", n, 32'd40);

    wr(A_DIV, 32'd2);
    for (int i = 0; i < 10; i++) wr(A_DATA, 32'h10 + i);
    rd(A_STATUS, d); chk("overflow_status", d, 32'h0000_008B);
    wr(A_STATUS, 32'd0);
    rd(A_STATUS, d); chk("overflow_cleared", d, 32'h0000_0083);
    cyc(200);

    wr(A_DIV, 32'd4);
    wr(A_DATA, 32'hA3);
    wr(A_DATA, 32'h5C);
    wr(A_DIV, 32'd3);
    capture(100, txs, bsy);
    runs = 0; cur = 0; lastrun = 0; gap = 0;
    for (int j = 0; j < 100; j++) begin
      if (bsy[j]) cur++;
      else begin
        if (cur > 0) begin runs++; lastrun = cur; end
        if (runs == 1) gap++;
        cur = 0;
      end
    end
    chk("div_change_runs", runs, 32'd2);
    chk("div_change_second_frame", lastrun, 32'd30);
    chk("div_change_gap", gap, 32'd1);

    wr(A_DIV, 32'd0);
    rd(A_DIV, d); chk("div_zero_reads_one", d, 32'd1);
    wr(A_DATA, 32'hA5);
    capture(20, txs, bsy);
    n = 0;
    for (int j = 0; j < 20; j++) n += bsy[j];
    chk("busy_cycles_div1", n, 32'd10);

    wr(A_DIV, 32'd4);
    wr(A_DATA, 32'h3C);
    wr(A_DATA, 32'h81);
    cyc(15);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("reset_mid_tx", {31'd0, tx}, 32'd1);
    rd(A_STATUS, d); chk("reset_mid_status", d, 32'h0000_0004);
    capture(60, txs, bsy);
    ones = 0;
    for (int j = 0; j < 60; j++) ones += txs[j];
    chk("no_start_after_reset", ones, 32'd60);

    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: wr(A_DATA | $urandom_range(0, 3), $urandom);
        4:          wr(A_DIV, $urandom_range(0, 3) | ($urandom & 32'hFFFF_0000));
        5:          wr(A_STATUS, $urandom);
        6:          wr(A_RSVD, $urandom);
        7:          rd(A_DATA | ($urandom_range(0, 15)), d);
        8:          wr(32'h0000_0800 | $urandom_range(0, 15), $urandom);
        default:    cyc($urandom_range(1, 30));
      endcase
    end
    cyc(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
